ml_readout_scheduler: RTL and testbench
=======================================

Name: ml_readout_scheduler

Overview:
- Shares one ml_interface inference engine between NUM_CH qubit readout channels.
- Each channel posts accumulated I/Q words into a one-deep pending slot.
- A round-robin arbiter issues one word at a time to the engine, waits for its done strobe, and returns the probability and state tagged with the channel index.
- Includes a watchdog so a stalled engine cannot hang readout; sits between the per-channel accumulators and ml_interface.

Parameters:
- NUM_CH, 4, number of readout channels (2..16).
- IN_W, 32, width of one I or Q accumulated component; data word is 2*IN_W.
- OUT_W, 18, width of the engine probability output.
- TIMEOUT, 1024, max cycles in WAIT before abort (>=16).
- CH_W, clog2(NUM_CH), channel index width (derived, localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ch_valid  in  NUM_CH  per-channel one-cycle strobe: ch_data slice valid.
- ch_data  in  NUM_CH*2*IN_W  channel i word at bits [i*2*IN_W +: 2*IN_W].
- ch_overflow  out  NUM_CH  one-cycle pulse: strobe dropped because slot full.
- eng_start  out  1  start_trigger to engine, one-cycle pulse.
- eng_data  out  2*IN_W  accumulated_data to engine, held stable from start until done.
- eng_idle  in  1  engine idle.
- eng_done  in  1  engine done_trigger.
- eng_prob  in  OUT_W  engine inference_prob.
- eng_state  in  1  engine inference_state.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  CH_W  channel of result.
- res_prob  out  OUT_W  captured probability (0 on timeout).
- res_state  out  1  captured state (0 on timeout).
- res_timeout  out  1  result is an abort.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1): every output is 0; pending slots cleared; rr pointer=0; FSM=IDLE; watchdog=0. The engine keeps its own reset; this block does not drive it.
- Capture: ch_valid[i] with slot i empty -> slot i loaded, pending[i]=1 next cycle.
  - Slot full and not being granted this cycle -> word dropped, ch_overflow[i]=1 next cycle, slot unchanged.
  - Slot being granted on the same cycle -> new word accepted; pending stays 1 with the new data.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE: if any pending and eng_idle=1, grant the first pending channel at or after rr_ptr (wrapping); latch its word into eng_data; clear its pending bit; go ISSUE. Otherwise stay.
  - ISSUE: eng_start=1 for exactly this cycle; watchdog cleared; go WAIT.
  - WAIT: watchdog increments each cycle.
    - eng_done=1: latch eng_prob and eng_state, res_timeout=0, go RESULT.
    - Watchdog reaches TIMEOUT-1 without done: res_prob=0, res_state=0, res_timeout=1, go RESULT.
    - eng_done on the same cycle as timeout: done wins.
  - RESULT: res_valid=1 for exactly this cycle with res_ch=granted index; rr_ptr=granted+1 (wraps NUM_CH-1 -> 0); go IDLE.
- Latency: ch_valid at cycle N with engine idle and no competition -> eng_start at N+3 (N+1 pending, N+2 grant, N+3 ISSUE). res_valid is 1 cycle after eng_done.
- eng_data is held from ISSUE until the next grant.
- res_* fields are held until the next RESULT; only res_valid pulses.
- eng_done outside WAIT is ignored.
- Max one outstanding engine job; back-to-back jobs need at least 3 cycles of gap.
- Fairness: with all channels continuously pending, grants rotate 0,1,..,NUM_CH-1,0,...

Decomposition:
- Shared package ml_pkg: IN_W=32, OUT_W=18, default TIMEOUT, FSM state enum (2-bit), function clog2.
- One sub-module, rr_arbiter: NUM_CH request vector plus rr_ptr in, grant index and any_grant out; purely combinational.
- Slots, FSM, watchdog and result registers stay in ml_readout_scheduler.

Test Plan:
- Single request: ch_valid[2] with data 0x00000010_00000020, eng_idle=1, bench engine done 5 cycles after start with prob 0x1ABCD, state 1 -> eng_start 3 cycles after strobe, eng_data equals the word, res_valid 1 cycle after done, res_ch=2, res_prob=0x1ABCD, res_state=1, res_timeout=0.
- Round robin: all four channels strobed in the same cycle -> grant order 0,1,2,3; then re-strobe 3 and 1 -> order 1,3 (rr_ptr=0 after 3 wraps).
- Overflow: strobe ch1 twice while a ch0 job is in WAIT -> second strobe raises ch_overflow[1] for one cycle; the first word is processed.
- Same-cycle capture: ch0 strobes on its grant cycle -> no overflow; ch0 is served again with the new word.
- Timeout: TIMEOUT=16, engine never asserts done -> res_valid 16 cycles after entering WAIT, res_timeout=1, res_prob=0, FSM back in IDLE; a later job completes normally.
- Async reset in WAIT: rst pulsed mid-cycle -> all outputs 0 immediately, pending cleared, no res_valid after release; a late eng_done is ignored.

Source files
------------

// File: rtl/ml_pkg.sv
// Shared constants, FSM encoding and helpers for the ML readout scheduler slice.
package ml_pkg;

    localparam int ML_IN_W    = 32;
    localparam int ML_OUT_W   = 18;
    localparam int ML_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } ml_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr, wrapping.
module rr_arbiter
    import ml_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_grant
);

    logic [CH_W:0] cand;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // One spare bit so ptr+k never overflows before the modulo fold.
            cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
            if (!any_grant && req[cand[CH_W-1:0]]) begin
                any_grant = 1'b1;
                grant     = cand[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ml_readout_scheduler.sv
// Shares one ML inference engine between NUM_CH readout channels with
// one-deep pending slots, round-robin issue and a stall watchdog.
module ml_readout_scheduler
    import ml_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int IN_W    = ML_IN_W,
    parameter  int OUT_W   = ML_OUT_W,
    parameter  int TIMEOUT = ML_TIMEOUT,
    localparam int CH_W    = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*2*IN_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_overflow,
    output logic                     eng_start,
    output logic [2*IN_W-1:0]        eng_data,
    input  logic                     eng_idle,
    input  logic                     eng_done,
    input  logic [OUT_W-1:0]         eng_prob,
    input  logic                     eng_state,
    output logic                     res_valid,
    output logic [CH_W-1:0]          res_ch,
    output logic [OUT_W-1:0]         res_prob,
    output logic                     res_state,
    output logic                     res_timeout,
    output logic                     busy
);

    localparam int DW   = 2 * IN_W;
    localparam int WD_W = clog2(TIMEOUT);

    ml_state_e         state;
    logic [NUM_CH-1:0] pending;
    logic [DW-1:0]     slot [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   arb_ch;
    logic              arb_any;
    logic              do_grant;
    logic [NUM_CH-1:0] grant_vec;
    logic [NUM_CH-1:0] accept;
    logic [WD_W-1:0]   wd;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (pending),
        .rr_ptr    (rr_ptr),
        .grant     (arb_ch),
        .any_grant (arb_any)
    );

    assign do_grant  = (state == ST_IDLE) && arb_any && eng_idle;
    assign grant_vec = do_grant ? (NUM_CH'(1) << arb_ch) : '0;
    // A slot being drained this cycle can take a fresh word without overflowing.
    assign accept    = ch_valid & (~pending | grant_vec);
    assign rr_next   = (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) slot[i] <= ch_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            ch_overflow <= '0;
        end else begin
            pending     <= (pending & ~grant_vec) | accept;
            ch_overflow <= ch_valid & pending & ~grant_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_ch    <= '0;
            wd          <= '0;
            eng_start   <= 1'b0;
            eng_data    <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_prob    <= '0;
            res_state   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (do_grant) begin
                        grant_ch <= arb_ch;
                        eng_data <= slot[arb_ch];
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    eng_start <= 1'b1;
                    wd        <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a simultaneous watchdog expiry
                    if (eng_done) begin
                        res_valid   <= 1'b1;
                        res_ch      <= grant_ch;
                        res_prob    <= eng_prob;
                        res_state   <= eng_state;
                        res_timeout <= 1'b0;
                        state       <= ST_RESULT;
                    end else if (wd == WD_W'(TIMEOUT-1)) begin
                        res_valid   <= 1'b1;
                        res_ch      <= grant_ch;
                        res_prob    <= '0;
                        res_state   <= 1'b0;
                        res_timeout <= 1'b1;
                        state       <= ST_RESULT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RESULT: begin
                    rr_ptr <= rr_next;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ml_readout_scheduler.sv
// Randomized bench for ml_readout_scheduler with a behavioural engine and scheduling model.
module tb_ml_readout_scheduler;

    localparam int NUM_CH  = 4;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 18;
    localparam int TIMEOUT = 16;
    localparam int CH_W    = 2;
    localparam int DW      = 2 * IN_W;
    localparam int OUTS_W  = 1 + DW + 1 + CH_W + OUT_W + 3 + NUM_CH;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DW-1:0]     ch_data;
    logic [NUM_CH-1:0]        ch_overflow;
    logic                     eng_start;
    logic [DW-1:0]            eng_data;
    logic                     eng_idle;
    logic                     eng_done;
    logic [OUT_W-1:0]         eng_prob;
    logic                     eng_state;
    logic                     res_valid;
    logic [CH_W-1:0]          res_ch;
    logic [OUT_W-1:0]         res_prob;
    logic                     res_state;
    logic                     res_timeout;
    logic                     busy;

    ml_readout_scheduler #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_overflow(ch_overflow),
        .eng_start(eng_start), .eng_data(eng_data), .eng_idle(eng_idle), .eng_done(eng_done),
        .eng_prob(eng_prob), .eng_state(eng_state), .res_valid(res_valid), .res_ch(res_ch),
        .res_prob(res_prob), .res_state(res_state), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              ch;
        logic [OUT_W-1:0] prob;
        logic            st;
        logic            to;
        int              cyc;
    } res_t;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    res_t        res_q[$];
    logic [DW-1:0] start_data_q[$];
    int          start_cyc_q[$];
    int          ovf_cnt [NUM_CH];
    int          last_done_cyc = 0;
    int          exp_q[$];
    int          rr_model = 0;
    logic [DW-1:0] word [NUM_CH];

    // behavioural engine knobs
    int          eng_lat = 5;
    bit          eng_hang = 1'b0;
    bit          resp_fixed = 1'b0;
    logic [OUT_W-1:0] fixed_prob = '0;
    logic        fixed_state = 1'b0;
    int          eng_cnt = 0;
    logic [DW-1:0] eng_job = '0;

    function automatic logic [OUT_W-1:0] fn_prob(input logic [DW-1:0] d);
        return d[OUT_W-1:0] ^ d[DW-1 -: OUT_W];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        eng_idle = 1'b1; eng_done = 1'b0; eng_prob = '0; eng_state = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (eng_done) begin eng_done = 1'b0; eng_idle = 1'b1; end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done  = 1'b1;
                    eng_prob  = resp_fixed ? fixed_prob : fn_prob(eng_job);
                    eng_state = resp_fixed ? fixed_state : ^eng_job;
                end
            end
            if (eng_start && !eng_hang) begin
                eng_job = eng_data; eng_cnt = eng_lat; eng_idle = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (res_valid) res_q.push_back('{int'(res_ch), res_prob, res_state, res_timeout, cyc});
        if (eng_start) begin start_data_q.push_back(eng_data); start_cyc_q.push_back(cyc); end
        if (eng_done) last_done_cyc = cyc;
        for (int i = 0; i < NUM_CH; i++) if (ch_overflow[i]) ovf_cnt[i]++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_obs();
        res_q = {}; start_data_q = {}; start_cyc_q = {}; exp_q = {};
        for (int i = 0; i < NUM_CH; i++) ovf_cnt[i] = 0;
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] mask);
        for (int i = 0; i < NUM_CH; i++) ch_data[i*DW +: DW] = word[i];
        ch_valid = mask;
        tick(1);
        ch_valid = '0;
    endtask

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (res_q.size() < n && k < budget) begin tick(1); k++; end
    endtask

    task automatic wait_start(input int n, input int budget);
        int k = 0;
        while (start_data_q.size() < n && k < budget) begin tick(1); k++; end
    endtask

    task automatic wait_quiet();
        int k = 0;
        while ((busy || !eng_idle || eng_cnt != 0 || eng_done) && k < 300) begin tick(1); k++; end
        tick(1);
    endtask

    // Grant order when every channel in mask is pending at once and nothing else arrives.
    task automatic model_order(input logic [NUM_CH-1:0] mask);
        int base = rr_model;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx = (base + k) % NUM_CH;
            if (mask[idx]) begin exp_q.push_back(idx); rr_model = (idx + 1) % NUM_CH; end
        end
    endtask

    task automatic test_reset();
        logic [OUTS_W-1:0] outs;
        rst = 1'b1; ch_valid = '0; ch_data = '0;
        tick(2);
        outs = {eng_start, eng_data, res_valid, res_ch, res_prob, res_state, res_timeout, busy, ch_overflow};
        compared++;
        if (outs !== '0) begin mismatched++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        for (int i = 0; i < NUM_CH; i++) word[i] = {$urandom, $urandom};
        strobe('1);
        tick(1);
        rst = 1'b0;
        clear_obs();
        tick(6);
        compared++;
        if (start_data_q.size() != 0) begin mismatched++; $display("FAIL reset_no_start: got %0d starts expected 0", start_data_q.size()); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rr_model = 0;
    endtask

    task automatic test_round_robin();
        logic [NUM_CH-1:0] masks [2];
        masks[0] = 4'b1111;
        masks[1] = 4'b1010;
        for (int r = 0; r < 2; r++) begin
            wait_quiet(); clear_obs();
            resp_fixed = 1'b0; eng_lat = $urandom_range(1, 6);
            for (int i = 0; i < NUM_CH; i++) word[i] = {$urandom, $urandom};
            model_order(masks[r]);
            strobe(masks[r]);
            wait_res(exp_q.size(), 300);
            compared++;
            if (res_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rr_count: got %0d expected %0d", res_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < res_q.size(); k++) begin
                compared++;
                if (res_q[k].ch != exp_q[k]) begin mismatched++; $display("FAIL rr_order[%0d]: got ch %0d expected %0d", k, res_q[k].ch, exp_q[k]); end
                compared++;
                if (res_q[k].prob !== fn_prob(word[exp_q[k]])) begin mismatched++; $display("FAIL rr_prob[%0d]: got %h expected %h", k, res_q[k].prob, fn_prob(word[exp_q[k]])); end
                compared++;
                if (start_data_q[k] !== word[exp_q[k]]) begin mismatched++; $display("FAIL rr_data[%0d]: got %h expected %h", k, start_data_q[k], word[exp_q[k]]); end
            end
        end
    endtask

    task automatic test_single();
        int t0;
        wait_quiet(); clear_obs();
        resp_fixed = 1'b1; fixed_prob = 18'h1ABCD; fixed_state = 1'b1; eng_lat = 5;
        word[2] = 64'h00000010_00000020;
        t0 = cyc;
        strobe(4'b0100);
        wait_res(1, 60);
        compared++;
        if (res_q.size() != 1 || start_cyc_q.size() != 1) begin
            mismatched++; $display("FAIL single_count: got %0d results %0d starts expected 1/1", res_q.size(), start_cyc_q.size());
        end else begin
            compared++;
            if (start_cyc_q[0] != t0 + 3) begin mismatched++; $display("FAIL single_latency: got start at %0d expected %0d", start_cyc_q[0], t0 + 3); end
            compared++;
            if (start_data_q[0] !== word[2]) begin mismatched++; $display("FAIL single_data: got %h expected %h", start_data_q[0], word[2]); end
            compared++;
            if (res_q[0].cyc != last_done_cyc + 1) begin mismatched++; $display("FAIL single_res_lat: got %0d expected %0d", res_q[0].cyc, last_done_cyc + 1); end
            compared++;
            if (res_q[0].ch != 2 || res_q[0].prob !== 18'h1ABCD || res_q[0].st !== 1'b1 || res_q[0].to !== 1'b0) begin
                mismatched++; $display("FAIL single_result: got ch %0d prob %h st %b to %b expected 2 1abcd 1 0", res_q[0].ch, res_q[0].prob, res_q[0].st, res_q[0].to);
            end
        end
        tick(3);
        compared++;
        if (res_prob !== 18'h1ABCD || res_valid !== 1'b0) begin mismatched++; $display("FAIL single_hold: got prob %h valid %b expected 1abcd 0", res_prob, res_valid); end
        resp_fixed = 1'b0;
        rr_model = 3;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w1a;
        wait_quiet(); clear_obs();
        eng_lat = 12;
        word[0] = {$urandom, $urandom};
        strobe(4'b0001);
        wait_start(1, 20);
        w1a = {$urandom, $urandom};
        word[1] = w1a;
        strobe(4'b0010);
        word[1] = ~w1a;
        strobe(4'b0010);
        tick(2);
        compared++;
        if (ovf_cnt[1] != 1 || ovf_cnt[0] != 0) begin mismatched++; $display("FAIL ovf_pulse: got ch1 %0d ch0 %0d cycles expected 1/0", ovf_cnt[1], ovf_cnt[0]); end
        wait_res(2, 100);
        compared++;
        if (res_q.size() != 2 || start_data_q.size() != 2) begin
            mismatched++; $display("FAIL ovf_count: got %0d results expected 2", res_q.size());
        end else begin
            compared++;
            if (res_q[0].ch != 0 || res_q[1].ch != 1) begin mismatched++; $display("FAIL ovf_order: got %0d,%0d expected 0,1", res_q[0].ch, res_q[1].ch); end
            compared++;
            if (start_data_q[1] !== w1a) begin mismatched++; $display("FAIL ovf_kept_word: got %h expected %h", start_data_q[1], w1a); end
        end
        rr_model = 2;
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] wa, wb;
        wait_quiet(); clear_obs();
        eng_lat = 3;
        wa = {$urandom, $urandom}; wb = {$urandom, $urandom};
        word[0] = wa; strobe(4'b0001);
        word[0] = wb; strobe(4'b0001);
        wait_res(2, 100);
        compared++;
        if (ovf_cnt[0] != 0) begin mismatched++; $display("FAIL same_cycle_ovf: got %0d expected 0", ovf_cnt[0]); end
        compared++;
        if (res_q.size() != 2 || start_data_q.size() != 2) begin
            mismatched++; $display("FAIL same_cycle_count: got %0d results expected 2", res_q.size());
        end else begin
            compared++;
            if (res_q[0].ch != 0 || res_q[1].ch != 0) begin mismatched++; $display("FAIL same_cycle_ch: got %0d,%0d expected 0,0", res_q[0].ch, res_q[1].ch); end
            compared++;
            if (start_data_q[0] !== wa || start_data_q[1] !== wb) begin mismatched++; $display("FAIL same_cycle_data: got %h,%h expected %h,%h", start_data_q[0], start_data_q[1], wa, wb); end
        end
        rr_model = 1;
    endtask

    task automatic test_timeout();
        wait_quiet(); clear_obs();
        eng_hang = 1'b1;
        word[3] = {$urandom, $urandom};
        strobe(4'b1000);
        wait_start(1, 20);
        wait_res(1, 60);
        compared++;
        if (res_q.size() != 1 || start_cyc_q.size() != 1) begin
            mismatched++; $display("FAIL timeout_count: got %0d results expected 1", res_q.size());
        end else begin
            compared++;
            if (res_q[0].cyc != start_cyc_q[0] + TIMEOUT) begin mismatched++; $display("FAIL timeout_latency: got %0d expected %0d", res_q[0].cyc, start_cyc_q[0] + TIMEOUT); end
            compared++;
            if (res_q[0].to !== 1'b1 || res_q[0].prob !== '0 || res_q[0].st !== 1'b0 || res_q[0].ch != 3) begin
                mismatched++; $display("FAIL timeout_result: got to %b prob %h st %b ch %0d expected 1 0 0 3", res_q[0].to, res_q[0].prob, res_q[0].st, res_q[0].ch);
            end
        end
        tick(2);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL timeout_idle: got busy %b expected 0", busy); end
        eng_hang = 1'b0; eng_lat = 4;
        clear_obs();
        word[1] = {$urandom, $urandom};
        strobe(4'b0010);
        wait_res(1, 60);
        compared++;
        if (res_q.size() != 1) begin
            mismatched++; $display("FAIL timeout_recover_count: got %0d expected 1", res_q.size());
        end else begin
            compared++;
            if (res_q[0].to !== 1'b0 || res_q[0].ch != 1 || res_q[0].prob !== fn_prob(word[1])) begin
                mismatched++; $display("FAIL timeout_recover: got to %b ch %0d prob %h expected 0 1 %h", res_q[0].to, res_q[0].ch, res_q[0].prob, fn_prob(word[1]));
            end
        end
        rr_model = 2;
    endtask

    task automatic test_async_reset();
        logic [OUTS_W-1:0] outs;
        wait_quiet(); clear_obs();
        eng_lat = 10;
        word[0] = {$urandom, $urandom}; word[1] = {$urandom, $urandom};
        strobe(4'b0011);
        wait_start(1, 20);
        tick(2);
        #2 rst = 1'b1;
        #1;
        outs = {eng_start, eng_data, res_valid, res_ch, res_prob, res_state, res_timeout, busy, ch_overflow};
        compared++;
        if (outs !== '0) begin mismatched++; $display("FAIL async_reset_outputs: got %h expected 0", outs); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(20);
        compared++;
        if (res_q.size() != 0) begin mismatched++; $display("FAIL async_reset_no_result: got %0d results expected 0", res_q.size()); end
        compared++;
        if (start_data_q.size() != 1) begin mismatched++; $display("FAIL async_reset_pending: got %0d starts expected 1", start_data_q.size()); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        rr_model = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [NUM_CH-1:0] mask;
            wait_quiet(); clear_obs();
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            eng_lat = $urandom_range(1, 8);
            for (int i = 0; i < NUM_CH; i++) word[i] = {$urandom, $urandom};
            model_order(mask);
            strobe(mask);
            wait_res(exp_q.size(), 300);
            compared++;
            if (res_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rand_count[%0d]: got %0d expected %0d", r, res_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < res_q.size(); k++) begin
                compared++;
                if (res_q[k].ch != exp_q[k] || res_q[k].to !== 1'b0) begin
                    mismatched++; $display("FAIL rand_order[%0d.%0d]: got ch %0d to %b expected %0d 0", r, k, res_q[k].ch, res_q[k].to, exp_q[k]);
                end
                compared++;
                if (res_q[k].prob !== fn_prob(word[exp_q[k]]) || res_q[k].st !== ^word[exp_q[k]]) begin
                    mismatched++; $display("FAIL rand_result[%0d.%0d]: got %h/%b expected %h/%b", r, k, res_q[k].prob, res_q[k].st, fn_prob(word[exp_q[k]]), ^word[exp_q[k]]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) ovf_cnt[i] = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_overflow();
        test_same_cycle();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
